// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-lite SRAM slave with byte lanes, wait states, ERROR response and write-to-read bypass
module ahb_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 7168,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h0000_1000,
  parameter int WAIT_READ = 0,
  parameter int WAIT_WRITE = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hreadyin,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BYTES);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t state, state_n;
  logic [3:0] cnt, wait_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic [BYTES-1:0] strb_q, strb_n, byp_strb;
  logic write_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q, byp_data, rdata;
  logic [ADDR_WIDTH-1:0] rel;
  logic [7:0] size_mask;
  logic done, complete, accept, err, misalign, wr_commit, unused;

  assign unused = i_htrans[0];
  assign rel = i_haddr - BASE_ADDR;
  assign idx_n = IDXW'(rel >> OFFW);
  assign size_mask = i_hsize == 3'd0 ? 8'h01 : i_hsize == 3'd1 ? 8'h03 : i_hsize == 3'd2 ? 8'h0f : 8'hff;
  assign strb_n = BYTES'(size_mask << i_haddr[OFFW-1:0]);
  assign misalign = (i_hsize == 3'd1 && i_haddr[0]) || (i_hsize == 3'd2 && |i_haddr[1:0])
                 || (i_hsize >= 3'd3 && |i_haddr[2:0]);
  assign err = i_haddr < BASE_ADDR || {1'b0, i_haddr} >= END_ADDR || misalign || i_hsize > 3'(OFFW);
  assign wait_n = write_q ? 4'(WAIT_WRITE) : 4'(WAIT_READ);
  assign done = state == DATA && cnt == wait_n;
  assign complete = state == IDLE || state == ERR2 || done;
  assign accept = complete && i_hsel && i_hreadyin && i_htrans[1];
  assign wr_commit = done && write_q;

  always_ff @(posedge i_hclk or negedge i_hreset)
    if (!i_hreset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == DATA && !done) ? cnt + 4'd1 : '0;
    end

  always_comb state_n = complete ? (accept ? (err ? ERR1 : DATA) : IDLE) : state == ERR1 ? ERR2 : DATA;

  always_comb begin
    rdata = rd_q;
    for (int k = 0; k < BYTES; k++)
      if (byp_strb[k]) rdata[8*k +: 8] = byp_data[8*k +: 8];
    o_hreadyout = state == ERR1 ? 1'b0 : state == DATA ? done : 1'b1;
    o_hresp = state == ERR1 || state == ERR2;
    o_hrdata = done && !write_q ? rdata : '0;
  end

  // a read accepted on the edge that commits a write to the same word sees the new bytes via the bypass
  always_ff @(posedge i_hclk or negedge i_hreset)
    if (!i_hreset) begin
      idx_q <= '0;
      strb_q <= '0;
      write_q <= 1'b0;
      byp_strb <= '0;
      byp_data <= '0;
    end else if (accept) begin
      idx_q <= idx_n;
      strb_q <= strb_n;
      write_q <= i_hwrite;
      byp_strb <= wr_commit && idx_q == idx_n ? strb_q : '0;
      byp_data <= i_hwdata;
    end

  always_ff @(posedge i_hclk)
    if (accept && !err) rd_q <= mem[idx_n];

  always_ff @(posedge i_hclk)
    if (wr_commit)
      for (int k = 0; k < BYTES; k++)
        if (strb_q[k]) mem[idx_q][8*k +: 8] <= i_hwdata[8*k +: 8];
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: pipelined AHB master with a scoreboard, driving a zero-wait and a waited slave
module tb_ahb_sram_slave;
  logic clk = 1'b0, hreset = 1'b0;
  logic hsel0 = 1'b0, hsel1 = 1'b0, hwrite = 1'b0, force_rdy = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [2:0] hsize = 3'd2;
  logic [1:0] htrans = 2'b00;
  logic rdy0, rdy1, resp0, resp1, hreadyin;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;
  assign hreadyin = rdy0 & rdy1 & force_rdy;

  ahb_sram_slave dut0 (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel0), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hsize(hsize), .i_htrans(htrans), .i_hreadyin(hreadyin), .i_hwdata(hwdata),
    .o_hreadyout(rdy0), .o_hresp(resp0), .o_hrdata(rd0));

  ahb_sram_slave #(.WAIT_READ(3), .WAIT_WRITE(2)) dut1 (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel1), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hsize(hsize), .i_htrans(htrans), .i_hreadyin(hreadyin), .i_hwdata(hwdata),
    .o_hreadyout(rdy1), .o_hresp(resp1), .o_hrdata(rd1));

  typedef struct {
    logic [1:0] tr;
    bit t;
    bit wr;
    logic [31:0] addr;
    logic [2:0] size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    bit t;
    bit wr;
    bit err;
    bit has_old;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] old;
    int waits;
  } exp_t;

  xfer_t stim[$];
  exp_t sb[$];
  logic [31:0] model [bit [32:0]];
  int checks = 0, passed = 0;

  task automatic push(input bit t, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [1:0] tr = 2'b10);
    stim.push_back('{tr, t, wr, addr, size, wdata});
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    return a < 32'h1000 || a >= 32'h8000 || s > 3'd2 || (a & ((32'd1 << s) - 32'd1)) != 32'd0;
  endfunction

  task automatic accept_xfer(input xfer_t x);
    exp_t e;
    bit [32:0] key;
    logic [31:0] w;
    int l;
    key = {x.t, x.addr & 32'hFFFF_FFFC};
    e.t = x.t;
    e.wr = x.wr;
    e.addr = x.addr;
    e.wdata = x.wdata;
    e.err = is_err(x.addr, x.size);
    e.waits = e.err ? 1 : x.wr ? (x.t ? 2 : 0) : (x.t ? 3 : 0);
    e.has_old = !e.err && model.exists(key);
    e.old = e.has_old ? model[key] : 32'h0;
    if (!e.err && x.wr) begin
      w = e.old;
      for (int k = 0; k < (1 << x.size); k++) begin
        l = int'(x.addr[1:0]) + k;
        w[8*l +: 8] = x.wdata[8*l +: 8];
      end
      model[key] = w;
    end
    sb.push_back(e);
  endtask

  // Issues every queued transfer with address/data phases overlapped, retiring expectations as data phases complete.
  task automatic run(input string name);
    int stall = 0, budget = 0;
    logic rdy;
    logic [31:0] want;
    exp_t e;
    xfer_t x;
    while ((stim.size() > 0 || sb.size() > 0) && budget < 500) begin
      budget++;
      if (stim.size() > 0) begin
        htrans = stim[0].tr; hsel0 = !stim[0].t; hsel1 = stim[0].t;
        haddr = stim[0].addr; hwrite = stim[0].wr; hsize = stim[0].size;
      end else begin
        htrans = 2'b00; hsel0 = 1'b0; hsel1 = 1'b0;
      end
      hwdata = sb.size() > 0 ? sb[0].wdata : 32'h0;
      @(negedge clk);
      rdy = hreadyin;
      if (sb.size() > 0 && !rdy) begin
        stall++;
        checks++;
        if ((resp0 | resp1) !== sb[0].err || (rd0 | rd1) !== 32'h0)
          $display("FAIL %s stall@%h: resp=%b rdata=%h want resp=%b rdata=0", name, sb[0].addr, resp0 | resp1, rd0 | rd1, sb[0].err);
        else passed++;
        if (sb[0].t && sb[0].wr && sb[0].has_old) begin
          checks++;
          if (dut1.mem[13'((sb[0].addr - 32'h1000) >> 2)] !== sb[0].old)
            $display("FAIL %s early_commit@%h: mem=%h want %h", name, sb[0].addr, dut1.mem[13'((sb[0].addr - 32'h1000) >> 2)], sb[0].old);
          else passed++;
        end
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        want = (!e.wr && !e.err) ? model_word(e) : 32'h0;
        checks++;
        if (stall != e.waits) $display("FAIL %s waits@%h: got %0d want %0d", name, e.addr, stall, e.waits);
        else passed++;
        checks++;
        if ((resp0 | resp1) !== e.err) $display("FAIL %s resp@%h: got %b want %b", name, e.addr, resp0 | resp1, e.err);
        else passed++;
        checks++;
        if ((rd0 | rd1) !== want) $display("FAIL %s rdata@%h: got %h want %h", name, e.addr, rd0 | rd1, want);
        else passed++;
        stall = 0;
      end else begin
        checks++;
        if (rdy !== 1'b1 || (resp0 | resp1) !== 1'b0 || (rd0 | rd1) !== 32'h0)
          $display("FAIL %s idle: ready=%b resp=%b rdata=%h want 1/0/0", name, rdy, resp0 | resp1, rd0 | rd1);
        else passed++;
      end
      @(posedge clk);
      if (rdy && stim.size() > 0) begin
        x = stim.pop_front();
        if (x.tr[1]) accept_xfer(x);
      end
      #1;
    end
    htrans = 2'b00; hsel0 = 1'b0; hsel1 = 1'b0;
    checks++;
    if (budget >= 500) $display("FAIL %s timeout: %0d transfers left, want 0", name, stim.size() + sb.size());
    else passed++;
  endtask

  // Expected read data: the model word snapshotted when the read's address phase was accepted.
  exp_t rd_snap[$];
  logic [31:0] snap_val[$];
  function automatic logic [31:0] model_word(input exp_t e);
    return e.old;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rdy0 !== 1'b1) $display("FAIL reset ready0: got %b want 1", rdy0); else passed++;
    checks++; if (resp0 !== 1'b0) $display("FAIL reset resp0: got %b want 0", resp0); else passed++;
    checks++; if (rd0 !== 32'h0) $display("FAIL reset rdata0: got %h want 0", rd0); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL reset ready1: got %b want 1", rdy1); else passed++;
    checks++; if (resp1 !== 1'b0) $display("FAIL reset resp1: got %b want 0", resp1); else passed++;
    checks++; if (rd1 !== 32'h0) $display("FAIL reset rdata1: got %h want 0", rd1); else passed++;
    hreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw();
    push(0, 1, 32'h1000, 3'd2, 32'hDEADBEEF);
    push(0, 0, 32'h0FF0 + 32'h10, 3'd2, 32'h0, 2'b00);
    push(0, 0, 32'h1000, 3'd2, 32'h0);
    run("word_rw");
  endtask

  task automatic test_bytes();
    push(0, 1, 32'h1004, 3'd0, {4{8'h11}});
    push(0, 1, 32'h1005, 3'd0, {4{8'h22}});
    push(0, 1, 32'h1006, 3'd0, {4{8'h33}});
    push(0, 1, 32'h1007, 3'd0, {4{8'h44}});
    push(0, 1, 32'h1006, 3'd1, {2{16'hAABB}});
    push(0, 0, 32'h1004, 3'd2, 32'h0);
    run("bytes");
    checks++;
    if (model[{1'b0, 32'h1004}] !== 32'hAABB2211) $display("FAIL bytes model: got %h want aabb2211", model[{1'b0, 32'h1004}]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    push(0, 1, 32'h2000, 3'd2, 32'h12345678);
    push(0, 0, 32'h2000, 3'd2, 32'h0);
    push(0, 1, 32'h2004, 3'd2, 32'hAAAA5555);
    push(0, 1, 32'h2008, 3'd2, 32'h13579BDF, 2'b11);
    push(0, 0, 32'h2004, 3'd2, 32'h0);
    push(0, 0, 32'h2008, 3'd2, 32'h0, 2'b11);
    push(0, 1, 32'h2009, 3'd0, {4{8'hEE}});
    push(0, 0, 32'h2008, 3'd2, 32'h0);
    push(0, 1, 32'h2000, 3'd2, 32'h0F0F0F0F);
    push(0, 0, 32'h2000, 3'd2, 32'h0);
    run("back_to_back");
  endtask

  task automatic test_wait_states();
    push(1, 1, 32'h1010, 3'd2, 32'hCAFEF00D);
    push(1, 1, 32'h1010, 3'd2, 32'h0BADC0DE);
    push(1, 0, 32'h1010, 3'd2, 32'h0);
    push(1, 1, 32'h1014, 3'd1, {2{16'h5AA5}});
    push(1, 0, 32'h1014, 3'd2, 32'h0);
    run("wait_states");
  endtask

  task automatic test_errors();
    push(0, 1, 32'h1008, 3'd2, 32'h01020304);
    push(0, 1, 32'h8000, 3'd2, 32'hFFFFFFFF);
    push(0, 0, 32'h0FFC, 3'd2, 32'h0);
    push(0, 1, 32'h1001, 3'd1, 32'hFFFFFFFF);
    push(0, 1, 32'h1008, 3'd3, 32'hFFFFFFFF);
    push(1, 1, 32'h8000, 3'd2, 32'hFFFFFFFF);
    push(0, 1, 32'h7FFC, 3'd2, 32'h7777AAAA);
    push(0, 0, 32'h7FFC, 3'd2, 32'h0);
    push(0, 0, 32'h1000, 3'd2, 32'h0);
    push(0, 0, 32'h1008, 3'd2, 32'h0);
    run("errors");
  endtask

  task automatic test_idle_busy();
    push(1, 1, 32'h1010, 3'd2, 32'hFFFFFFFF, 2'b00);
    push(1, 1, 32'h1010, 3'd2, 32'hFFFFFFFF, 2'b01);
    run("idle_busy");
    force_rdy = 1'b0;
    htrans = 2'b10; hsel1 = 1'b1; hwrite = 1'b1; haddr = 32'h1010; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hsel1 = 1'b0; force_rdy = 1'b1; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || resp1 !== 1'b0) $display("FAIL hreadyin_low: ready=%b resp=%b want 1/0", rdy1, resp1);
    else passed++;
    @(posedge clk); #1;
    push(1, 0, 32'h1010, 3'd2, 32'h0);
    run("idle_busy_readback");
  endtask

  task automatic test_reset_stall();
    htrans = 2'b10; hsel1 = 1'b1; hwrite = 1'b1; haddr = 32'h1010; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hsel1 = 1'b0; hwdata = 32'hBAD0BAD0;
    @(negedge clk);
    checks++; if (rdy1 !== 1'b0) $display("FAIL rst_stall ready: got %b want 0", rdy1); else passed++;
    #2 hreset = 1'b0;
    #1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL rst_stall ready_after: got %b want 1", rdy1); else passed++;
    checks++; if (resp1 !== 1'b0) $display("FAIL rst_stall resp_after: got %b want 0", resp1); else passed++;
    checks++; if (rd1 !== 32'h0) $display("FAIL rst_stall rdata_after: got %h want 0", rd1); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk) hreset = 1'b1;
    @(posedge clk); #1;
    push(1, 0, 32'h1010, 3'd2, 32'h0);
    run("rst_stall_readback");
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_bytes();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_idle_busy();
    test_reset_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-lite SRAM slave for the SoC data-memory region, and the next generation of our word-only data memory. Adds byte, halfword and word (and doubleword at 64-bit width) access with little-endian byte lanes, independent read/write wait states, a configurable base address and a two-cycle ERROR response for illegal transfers. Sits behind the AHB decoder/mux as one slave; the MIPS core's bus master reaches it through the interconnect.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; 32 or 64 only; BYTES = DATA_WIDTH/8
- MEM_DEPTH, 7168, memory depth in DATA_WIDTH words
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be BYTES-aligned
- WAIT_READ, 0, wait cycles inserted per read (0..15)
- WAIT_WRITE, 0, wait cycles inserted per write (0..15)
- i_hclk  in  1  bus clock; all state changes on the rising edge
- i_hreset  in  1  reset, asynchronous, active-low
- i_hsel  in  1  slave select from the decoder
- i_haddr  in  ADDR_WIDTH  byte address
- i_hwrite  in  1  1 = write, 0 = read
- i_hsize  in  3  000 byte, 001 halfword, 010 word, 011 doubleword
- i_htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- i_hreadyin  in  1  bus HREADY (muxed)
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase
- o_hreadyout  out  1  slave ready
- o_hresp  out  1  0 OKAY, 1 ERROR
- o_hrdata  out  DATA_WIDTH  read data

## Operation
- Valid address phase: i_hsel & i_hreadyin & i_htrans[1] at a rising edge. Latch addr, size and write into sample registers.
- IDLE/BUSY transfers, or no select: nothing is latched, and the next cycle is zero-wait OKAY.
- Error check at latch time. A transfer is an error if any of these holds:
  - addr < BASE_ADDR, or addr >= BASE_ADDR + MEM_DEPTH*BYTES
  - addr not aligned to 2^hsize
  - 2^hsize > BYTES
- Error transfers never touch memory.
- Word index = (addr - BASE_ADDR) >> log2(BYTES). Byte offset = addr[log2(BYTES)-1:0].
- Write strobes: 2^hsize consecutive lanes starting at lane = offset (little-endian). Only strobed bytes change; the i_hwdata byte for lane k is written to lane k.
- Read: o_hrdata returns the full word at the word index, all lanes. The master extracts the lanes it needs.
- FSM states:
  - IDLE: o_hreadyout=1, o_hresp=0
  - DATA: cnt counts 0..W, where W = WAIT_WRITE or WAIT_READ per the sampled direction; o_hreadyout = (cnt==W), o_hresp=0
  - ERR1: o_hreadyout=0, o_hresp=1
  - ERR2: o_hreadyout=1, o_hresp=1
- FSM transitions:
  - Completing cycles are IDLE, DATA with cnt==W, and ERR2. At each edge in a completing cycle: a valid address phase goes to ERR1 if it is an error, otherwise to DATA with cnt=0. Anything else goes to IDLE.
  - DATA with cnt<W: cnt+1.
  - ERR1 -> ERR2 unconditionally.
- No new address phase is accepted while o_hreadyout=0; i_hreadyin is low then by construction.
- o_hrdata is 0 except in the completing DATA cycle of a read.
- Memory contents are not reset, so block RAM can be inferred. Contents after reset are undefined.

## Timing
- Reset values: o_hreadyout=1, o_hresp=0, o_hrdata=0, FSM=IDLE, cnt=0, sample registers 0.
- Reset asserted mid-transfer aborts it; a pending write is not committed.
- Write commit: at the rising edge that ends the completing DATA cycle, using i_hwdata present in that cycle.
- Read latency: data is valid in the cycle with o_hreadyout=1, which is 1 + WAIT_READ cycles after the address-phase edge.
- Read-after-write to the same word in back-to-back transfers: the read returns the newly written bytes. The read's address phase coincides with the write's completing data phase, so forwarding or bypass is required.
- Write-after-read and pipelined SEQ bursts run at full rate when WAIT_* = 0.
- ERROR is always exactly two cycles and ignores WAIT_*.

## Test plan
- Reset, then NONSEQ word write 0xDEADBEEF to 0x1000, then word read 0x1000:
  - reads back 0xDEADBEEF
  - o_hreadyout never low with WAIT_*=0
  - o_hresp=0 throughout
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x1004..0x1007, then halfword write 0xAABB to 0x1006, then word read 0x1004 -> 0xAABB2211.
- Back-to-back write 0x12345678 to 0x2000 followed immediately by a read of 0x2000 -> read data phase returns 0x12345678 (bypass).
- WAIT_READ=3, WAIT_WRITE=2:
  - read shows o_hreadyout low for 3 cycles, then data with ready high
  - write shows 2 low cycles
  - memory is unchanged until the final edge
- Each of the following gives ERR1 then ERR2 (hreadyout 0 then 1, hresp 1 both cycles), and memory is unchanged:
  - word write to 0x8000
  - read of 0x0FFC
  - halfword at 0x1001
  - hsize=011 on a 32-bit bus
- IDLE/BUSY with i_hsel=1, and a NONSEQ with i_hreadyin=0 -> no state change, zero-wait OKAY. Assert reset during a WAIT_WRITE stall -> outputs return to reset values and the target word is unchanged.
